data_sram_resp: RTL
===================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter BASE_HI, default 16'hBFAF, meaning the required value of data_sram_addr[31:16] for an access to hit.
REQ-002 SHALL have parameter TICK_DIV, default 1, meaning clock cycles per timer increment (legal range 1..256).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_sram_en  input  1  access strobe.
REQ-006 SHALL have port data_sram_wen  input  4  byte write enables; 0 means read.
REQ-007 SHALL have port data_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port data_sram_wdata  input  32  write data.
REQ-009 SHALL have port data_sram_rdata  output  32  read data.
REQ-010 SHALL have port switch_in  input  8  asynchronous board switches.
REQ-011 SHALL have port led_out  output  16  LED register.
REQ-012 SHALL have port timer_irq  output  1  level interrupt, intended for ext_int[0].

Function
REQ-013 SHALL decode offset addr[15:0] when addr[31:16]==BASE_HI: 0x0000/4/8/C SCRATCH0-3 RW; 0xE000 TIMER RW; 0xE004 COMPARE RW; 0xE008 STATUS (bit0 irq pending, W1C); 0xF000 LED RW [15:0]; 0xF004 SWITCH RO [7:0].
REQ-014 SHALL perform a read when en=1 and wen=0, presenting data in data_sram_rdata exactly one cycle later.
REQ-015 SHALL hold data_sram_rdata unchanged on cycles without a read, including write cycles.
REQ-016 SHALL return 0 for reads of unmapped offsets, of offsets with addr[31:16]!=BASE_HI, and of unused register bits.
REQ-017 SHALL apply writes per byte lane using wen[i] -> bits [8i+7:8i]; writes to RO, unmapped or non-hit addresses are ignored.
REQ-018 SHALL increment TIMER by 1 once every TICK_DIV cycles using a prescaler counter, wrapping 0xFFFFFFFF->0.
REQ-019 SHALL give a TIMER write priority over the same-cycle increment and restart the prescaler from 0.
REQ-020 SHALL set irq pending in the cycle after TIMER transitions to a value equal to COMPARE, also when the equality is produced by a TIMER write.
REQ-021 SHALL clear irq pending on a COMPARE write, or on a STATUS write with wdata[0]=1 and wen[0]=1.
REQ-022 SHALL give set priority over clear when both occur in the same cycle.
REQ-023 SHALL drive timer_irq directly from the irq pending bit.
REQ-024 SHALL synchronize switch_in through two flops; SWITCH reads return the second-stage value.
REQ-025 SHALL drive led_out directly from the LED register.

Reset
REQ-026 SHALL on rst=1 set SCRATCH0-3, TIMER, prescaler, irq pending, synchronizer flops and data_sram_rdata to 0, COMPARE to 0xFFFFFFFF and LED to 0xFFFF, effective at the next edge.
REQ-027 SHALL discard any access presented while rst=1; a read issued in the cycle before reset asserts SHALL NOT appear on rdata.

Structure
REQ-028 SHALL place offset constants, the reset values and BASE_HI default in the shared defines header.
REQ-029 SHALL instantiate one sub-module, resp_timer, containing the prescaler, TIMER, COMPARE and irq logic.

Verification
REQ-030 SHALL cover: write 0xDEADBEEF to SCRATCH1, wen=4'b0011 write 0x0000_1234, read -> 0xDEAD1234 one cycle after the read strobe.
REQ-031 SHALL cover: TICK_DIV=1, write TIMER=0xFFFFFFFE, COMPARE=0x00000001 -> TIMER reads 0 after wrap, timer_irq=1 within 4 cycles; STATUS write 1 -> timer_irq=0.
REQ-032 SHALL cover: STATUS W1C in the same cycle the compare match sets -> timer_irq stays 1.
REQ-033 SHALL cover: read of 0xBFAF_1000 and of 0x1FAF_0000 -> rdata 0; write to SWITCH leaves its read value equal to the synchronized switch_in.
REQ-034 SHALL cover: switch_in=0xA5 -> SWITCH read returns 0xA5 no earlier than 2 cycles after the change.
REQ-035 SHALL cover: rst asserted mid-stream after LED=0x00FF -> led_out=0xFFFF, rdata=0, COMPARE reads 0xFFFFFFFF after release.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// Shared register map, reset values and byte-lane merge helper for the data SRAM
// response block.
package data_sram_resp_pkg;

  localparam logic [15:0] BASE_HI_DEFAULT = 16'hBFAF;

  localparam logic [15:0] OFF_SCRATCH0 = 16'h0000;
  localparam logic [15:0] OFF_SCRATCH1 = 16'h0004;
  localparam logic [15:0] OFF_SCRATCH2 = 16'h0008;
  localparam logic [15:0] OFF_SCRATCH3 = 16'h000C;
  localparam logic [15:0] OFF_TIMER    = 16'hE000;
  localparam logic [15:0] OFF_COMPARE  = 16'hE004;
  localparam logic [15:0] OFF_STATUS   = 16'hE008;
  localparam logic [15:0] OFF_LED      = 16'hF000;
  localparam logic [15:0] OFF_SWITCH   = 16'hF004;

  localparam logic [31:0] RST_SCRATCH = 32'h0000_0000;
  localparam logic [31:0] RST_TIMER   = 32'h0000_0000;
  localparam logic [31:0] RST_COMPARE = 32'hFFFF_FFFF;
  localparam logic [15:0] RST_LED     = 16'hFFFF;

  // Replace only the byte lanes whose write enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wen);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data SRAM style access bus: strobe, byte write enables, address, write and read data.
// Always ready; read data returns one cycle after the strobe.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp_timer.sv
// Prescaled free-running TIMER with COMPARE match and sticky irq pending bit.
// Register writes take effect at the next edge; no backpressure.
module resp_timer
  import data_sram_resp_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  timer_wen,
  input  logic [3:0]  compare_wen,
  input  logic        status_w1c,
  input  logic [31:0] wdata,
  output logic [31:0] timer_val,
  output logic [31:0] compare_val,
  output logic        irq
);

  localparam logic [7:0] TICK_MAX = 8'(TICK_DIV - 1);

  logic [7:0]  presc_q, presc_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic        pend_q, pend_d;
  logic        timer_ld;

  always_comb begin
    presc_d   = presc_q;
    timer_d   = timer_q;
    timer_ld  = 1'b0;
    compare_d = compare_q;
    pend_d    = pend_q;

    if (|timer_wen) begin
      timer_d  = merge_bytes(timer_q, wdata, timer_wen);
      presc_d  = 8'd0;
      timer_ld = 1'b1;
    end else if (presc_q == TICK_MAX) begin
      timer_d  = timer_q + 32'd1;
      presc_d  = 8'd0;
      timer_ld = 1'b1;
    end else begin
      presc_d = presc_q + 8'd1;
    end

    if (|compare_wen) compare_d = merge_bytes(compare_q, wdata, compare_wen);

    // Match is registered so pending rises the cycle after TIMER shows the value.
    match_d = timer_ld && (timer_d == compare_d);

    if ((|compare_wen) || status_w1c) pend_d = 1'b0;
    if (match_q)                      pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= 8'd0;
      timer_q   <= RST_TIMER;
      compare_q <= RST_COMPARE;
      match_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      pend_q    <= pend_d;
    end
  end

  assign timer_val   = timer_q;
  assign compare_val = compare_q;
  assign irq         = pend_q;

endmodule

// File: rtl/data_sram_resp.sv
// Memory-mapped scratch/timer/LED/switch register block on a data SRAM port.
// Reads return one cycle after the strobe; always ready, no backpressure.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter logic [15:0] BASE_HI  = BASE_HI_DEFAULT,
  parameter int          TICK_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  data_sram_resp_if.slave         bus,
  input  logic [7:0]              switch_in,
  output logic [15:0]             led_out,
  output logic                    timer_irq
);

  logic [31:0] scratch_q [4];
  logic [31:0] scratch_d [4];
  logic [15:0] led_q, led_d;
  logic [7:0]  sw_meta_q, sw_meta_d;
  logic [7:0]  sw_sync_q, sw_sync_d;
  logic [31:0] rdata_q, rdata_d;

  logic [15:0] off;
  logic        hit, wr, rd;
  logic [31:0] rd_val;
  logic [31:0] led_m;
  logic [3:0]  timer_wen, compare_wen;
  logic        status_w1c;
  logic [31:0] timer_val, compare_val;
  logic        irq;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

  always_comb begin
    off = {bus.data_sram_addr[15:2], 2'b00};
    hit = (bus.data_sram_addr[31:16] == BASE_HI);
    wr  = bus.data_sram_en && hit && (bus.data_sram_wen != 4'b0000);
    rd  = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);

    scratch_d   = scratch_q;
    led_d       = led_q;
    led_m       = merge_bytes({16'h0000, led_q}, bus.data_sram_wdata, bus.data_sram_wen);
    rd_val      = 32'h0000_0000;
    timer_wen   = 4'b0000;
    compare_wen = 4'b0000;
    status_w1c  = 1'b0;

    // Non-hit addresses fall through with rd_val=0 and no write side effects.
    if (hit) begin
      case (off)
        OFF_SCRATCH0, OFF_SCRATCH1, OFF_SCRATCH2, OFF_SCRATCH3: begin
          rd_val = scratch_q[off[3:2]];
          if (wr) scratch_d[off[3:2]] = merge_bytes(scratch_q[off[3:2]],
                                                    bus.data_sram_wdata, bus.data_sram_wen);
        end
        OFF_TIMER: begin
          rd_val = timer_val;
          if (wr) timer_wen = bus.data_sram_wen;
        end
        OFF_COMPARE: begin
          rd_val = compare_val;
          if (wr) compare_wen = bus.data_sram_wen;
        end
        OFF_STATUS: begin
          rd_val     = {31'd0, irq};
          status_w1c = wr && bus.data_sram_wen[0] && bus.data_sram_wdata[0];
        end
        OFF_LED: begin
          rd_val = {16'h0000, led_q};
          if (wr) led_d = led_m[15:0];
        end
        OFF_SWITCH: rd_val = {24'h000000, sw_sync_q};
        default: ;
      endcase
    end

    sw_meta_d = switch_in;
    sw_sync_d = sw_meta_q;
    rdata_d   = rd ? rd_val : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) scratch_q[i] <= RST_SCRATCH;
      led_q     <= RST_LED;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
      rdata_q   <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 4; i++) scratch_q[i] <= scratch_d[i];
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      rdata_q   <= rdata_d;
    end
  end

  resp_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .timer_wen   (timer_wen),
    .compare_wen (compare_wen),
    .status_w1c  (status_w1c),
    .wdata       (bus.data_sram_wdata),
    .timer_val   (timer_val),
    .compare_val (compare_val),
    .irq         (irq)
  );

  assign bus.data_sram_rdata = rdata_q;
  assign led_out             = led_q;
  assign timer_irq           = irq;

endmodule
